pulse_capture_multi: RTL

//  Multi-channel pulse timestamper for the photodiode front end. Each channel measures every

---
 rtl/pulse_capture_multi.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pulse_capture_multi.sv
// Multi-channel pulse timestamper: per-channel edge FSMs produce {channel, center, width}
// records, merged round-robin through 1-entry pending slots into a show-ahead output FIFO.
module pulse_capture_multi #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_WIDTH  = 2,
    parameter int MAX_WIDTH  = 2**20,
    parameter int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CHANNELS-1:0]           sig_in,
    input  logic [WIDTH-1:0]              counter,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHW-1:0]                out_channel,
    output logic [WIDTH-1:0]              out_center,
    output logic [WIDTH-1:0]              out_width,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_STUCK = 2'd2;

    // Widths are compared in 64 bits so MAX_WIDTH may exceed the counter range.
    function automatic logic at_least(input logic [WIDTH-1:0] w, input longint lim);
        return longint'(w) >= lim;
    endfunction

    logic [CHANNELS-1:0] sig_d_q;
    logic [1:0]          state_q [CHANNELS];
    logic [1:0]          state_d [CHANNELS];
    logic [WIDTH-1:0]    start_q [CHANNELS];
    logic [WIDTH-1:0]    start_d [CHANNELS];
    logic [WIDTH-1:0]    dur     [CHANNELS];
    logic [WIDTH-1:0]    rec_center [CHANNELS];
    logic [CHANNELS-1:0] rec_new;

    logic [CHANNELS-1:0] pend_vld_q, pend_vld_d, pend_load, drop;
    logic [WIDTH-1:0]    pend_center_q [CHANNELS];
    logic [WIDTH-1:0]    pend_width_q  [CHANNELS];

    logic [CHW-1:0]      last_grant_q, grant_idx;
    logic [CHANNELS-1:0] grant;
    logic                found, push, pop, full;

    logic [CHW-1:0]      mem_ch_q     [FIFO_DEPTH];
    logic [WIDTH-1:0]    mem_center_q [FIFO_DEPTH];
    logic [WIDTH-1:0]    mem_width_q  [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       count_q;
    logic                overflow_q;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            dur[i]        = counter - start_q[i];
            rec_center[i] = start_q[i] + (dur[i] >> 1);
        end
    end

    // Per-channel FSM: detect cycle is the stage feeding the pending slot register.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            start_d[i] = start_q[i];
            rec_new[i] = 1'b0;
            if (!enable) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (sig_in[i] && !sig_d_q[i]) begin
                            state_d[i] = ST_HIGH;
                            start_d[i] = counter;
                        end
                    end
                    ST_HIGH: begin
                        if (!sig_in[i]) begin
                            state_d[i] = ST_IDLE;
                            rec_new[i] = at_least(dur[i], longint'(MIN_WIDTH));
                        end else if (at_least(dur[i], longint'(MAX_WIDTH))) begin
                            state_d[i] = ST_STUCK;
                        end
                    end
                    ST_STUCK: begin
                        if (!sig_in[i]) state_d[i] = ST_IDLE;
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_q == LW'(FIFO_DEPTH));

    always_comb begin
        found     = 1'b0;
        grant_idx = last_grant_q;
        grant     = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!found && pend_vld_q[CHW'((int'(last_grant_q) + k) % CHANNELS)]) begin
                found     = 1'b1;
                grant_idx = CHW'((int'(last_grant_q) + k) % CHANNELS);
            end
        end
        push = found && (!full || pop);
        if (push) grant[grant_idx] = 1'b1;
    end

    // A slot freed by this cycle's grant can accept a new record in the same cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pend_vld_d[i] = pend_vld_q[i] & ~grant[i];
            drop[i]       = rec_new[i] & pend_vld_d[i];
            pend_load[i]  = rec_new[i] & ~pend_vld_d[i];
            if (pend_load[i]) pend_vld_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d_q      <= '0;
            pend_vld_q   <= '0;
            last_grant_q <= CHW'(CHANNELS - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= ST_IDLE;
        end else begin
            sig_d_q    <= sig_in;
            pend_vld_q <= pend_vld_d;
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
            if (push) last_grant_q <= grant_idx;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + LW'(push) - LW'(pop);
            if (|drop)             overflow_q <= 1'b1;
            else if (overflow_clr) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            start_q[i] <= start_d[i];
            if (pend_load[i]) begin
                pend_center_q[i] <= rec_center[i];
                pend_width_q[i]  <= dur[i];
            end
        end
        if (push) begin
            mem_ch_q[wr_ptr_q]     <= grant_idx;
            mem_center_q[wr_ptr_q] <= pend_center_q[grant_idx];
            mem_width_q[wr_ptr_q]  <= pend_width_q[grant_idx];
        end
    end

    assign out_channel = out_valid ? mem_ch_q[rd_ptr_q]     : '0;
    assign out_center  = out_valid ? mem_center_q[rd_ptr_q] : '0;
    assign out_width   = out_valid ? mem_width_q[rd_ptr_q]  : '0;
    assign fifo_level  = count_q;
    assign overflow    = overflow_q;

endmodule
